// File: rtl/pipe_trace_monitor.sv
// pipe_trace_monitor
// Retirement monitor for the 5-stage MIPS pipeline. It watches the writeback
// stage, counts every accepted retirement by instruction class, and keeps a
// trace of {pc, instr, wd} records in a FIFO. A run ends on a self-loop J
// (halt) or when the RUN cycle count reaches MAX_CYCLES (watchdog).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wb_valid          an instruction retires this cycle
//   wb_pc/instr/wd    PC, instruction word and write data of the retirement
//   trace_ready       consumer pops the FIFO head
//   trace_valid       FIFO non-empty
//   trace_pc/instr/wd FIFO head record (0 while empty)
//   trace_ovf         sticky: a record was dropped because the FIFO was full
//   cnt_sel           counter select (0 cycles, 1..9 classes, 10 total)
//   cnt_data          selected counter value, combinational read
//   done, done_cause  run ended; cause 01 halt, 10 timeout, 11 both
module pipe_trace_monitor #(
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_instr,
    input  logic [31:0]      wb_wd,
    input  logic             trace_ready,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_instr,
    output logic [31:0]      trace_wd,
    output logic             trace_ovf,
    input  logic [3:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_data,
    output logic             done,
    output logic [1:0]       done_cause
);

    localparam int AW   = $clog2(DEPTH);
    localparam int NCNT = 11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [AW:0]      FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_LIVE = CNT_W'(MAX_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [3:0] classify(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        if (instr == 32'd0) return 4'd1;
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 ||
                fn == 6'h2A || fn == 6'h00) return 4'd2;
            if (fn == 6'h19 || fn == 6'h10 || fn == 6'h12) return 4'd3;
            return 4'd9;
        end
        case (op)
            6'h23:       return 4'd4;
            6'h2B:       return 4'd5;
            6'h04:       return 4'd6;
            6'h02, 6'h03: return 4'd7;
            6'h09:       return 4'd8;
            default:     return 4'd9;
        endcase
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt [NCNT];

    logic [31:0] mem_pc    [DEPTH];
    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_wd    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        running;
    logic        accept;
    logic [3:0]  cls;
    logic [3:0]  pc4_hi;
    logic [31:0] jump_target;
    logic        halt;
    logic        timeout;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        drop;

    assign running = (state == ST_RUN);
    assign accept  = wb_valid && running;
    assign cls     = classify(wb_instr);

    // Top nibble of pc+4: bit 28 only sees a carry when pc[27:2] is all ones.
    assign pc4_hi      = wb_pc[31:28] + 4'(&wb_pc[27:2]);
    assign jump_target = {pc4_hi, wb_instr[25:0], 2'b00};
    assign halt        = accept && (wb_instr[31:26] == 6'h02) && (jump_target == wb_pc);

    // Fires on the RUN edge that moves the cycle counter onto MAX_CYCLES.
    assign timeout = running && (cnt[0] == LAST_LIVE);

    assign fifo_full = (count == FULL_CNT);
    assign pop       = trace_ready && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push      = accept && (!fifo_full || pop);
    assign drop      = accept && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            done       <= 1'b0;
            done_cause <= 2'b00;
            trace_ovf  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_RUN;
                ST_RUN: begin
                    if (halt || timeout) begin
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        done_cause <= {timeout, halt};
                    end
                end
                default: state <= ST_DONE;
            endcase

            if (running) cnt[0] <= sat_inc(cnt[0]);
            for (int i = 1; i < NCNT - 1; i++) begin
                if (accept && (cls == 4'(i))) cnt[i] <= sat_inc(cnt[i]);
            end
            if (accept) cnt[NCNT-1] <= sat_inc(cnt[NCNT-1]);

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) trace_ovf <= 1'b1;
        end
    end

    // Trace storage carries no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= wb_pc;
            mem_instr[wr_ptr] <= wb_instr;
            mem_wd[wr_ptr]    <= wb_wd;
        end
    end

    assign trace_valid = (count != '0);
    assign trace_pc    = trace_valid ? mem_pc[rd_ptr]    : 32'd0;
    assign trace_instr = trace_valid ? mem_instr[rd_ptr] : 32'd0;
    assign trace_wd    = trace_valid ? mem_wd[rd_ptr]    : 32'd0;

    always_comb begin
        cnt_data = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (cnt_sel == 4'(i)) cnt_data = cnt[i];
        end
    end

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Self-checking bench for pipe_trace_monitor: a classification table, hand
// sequences for halt, watchdog, FIFO overflow and mid-run reset, and random
// traffic compared cycle by cycle against a queue-based reference model.
module tb_pipe_trace_monitor;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
    localparam int MAXC  = 60;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wb_valid = 1'b0;
    logic [31:0]      wb_pc = '0;
    logic [31:0]      wb_instr = '0;
    logic [31:0]      wb_wd = '0;
    logic             trace_ready = 1'b0;
    logic             trace_valid;
    logic [31:0]      trace_pc;
    logic [31:0]      trace_instr;
    logic [31:0]      trace_wd;
    logic             trace_ovf;
    logic [3:0]       cnt_sel = '0;
    logic [CNT_W-1:0] cnt_data;
    logic             done;
    logic [1:0]       done_cause;

    always #50 clk = ~clk;

    pipe_trace_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_instr(wb_instr), .wb_wd(wb_wd), .trace_ready(trace_ready),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_instr(trace_instr),
        .trace_wd(trace_wd), .trace_ovf(trace_ovf), .cnt_sel(cnt_sel),
        .cnt_data(cnt_data), .done(done), .done_cause(done_cause)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: state 0 idle, 1 run, 2 done.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wd;
    } rec_t;

    int              mstate;
    longint unsigned mcnt [16];
    rec_t            mq [$];
    bit              movf;
    bit              mdone;
    logic [1:0]      mcause;

    localparam longint unsigned CMAX = (64'd1 << CNT_W) - 64'd1;

    function automatic longint unsigned msat(input longint unsigned v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic int ref_class(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (ins == 32'd0) return 1;
        if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00}) return 2;
            if (fn inside {6'h19, 6'h10, 6'h12}) return 3;
            return 9;
        end
        if (op == 6'h23) return 4;
        if (op == 6'h2B) return 5;
        if (op == 6'h04) return 6;
        if (op inside {6'h02, 6'h03}) return 7;
        if (op == 6'h09) return 8;
        return 9;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [31:0] wd, input bit rdy);
        bit          acc;
        bit          hlt;
        bit          to;
        bit          pp;
        logic [31:0] p4;
        logic [31:0] tgt;
        rec_t        rc;
        if (r) begin
            mstate = 0;
            foreach (mcnt[i]) mcnt[i] = 0;
            mq.delete();
            movf = 0; mdone = 0; mcause = 2'b00;
        end else begin
            acc = v && (mstate == 1);
            p4  = pc + 32'd4;
            tgt = {p4[31:28], ins[25:0], 2'b00};
            hlt = acc && (ins[31:26] == 6'h02) && (tgt == pc);
            to  = 0;
            pp  = rdy && (mq.size() > 0);
            if (mstate == 1) begin
                to = (mcnt[0] == MAXC - 1);
                mcnt[0] = msat(mcnt[0]);
            end
            if (acc) begin
                mcnt[ref_class(ins)] = msat(mcnt[ref_class(ins)]);
                mcnt[10] = msat(mcnt[10]);
            end
            if (pp) void'(mq.pop_front());
            if (acc) begin
                rc.pc = pc; rc.instr = ins; rc.wd = wd;
                if (mq.size() < DEPTH) mq.push_back(rc);
                else movf = 1;
            end
            if (mstate == 0) mstate = 1;
            else if (mstate == 1 && (hlt || to)) begin
                mstate = 2; mdone = 1; mcause = {to, hlt};
            end
        end
    endtask

    // Drive one cycle's inputs, advance the model, then step past the edge.
    task automatic cycle(input bit r, input bit v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [31:0] wd, input bit rdy);
        rst = r; wb_valid = v; wb_pc = pc; wb_instr = ins; wb_wd = wd; trace_ready = rdy;
        model_step(r, v, pc, ins, wd, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 32'd0, 32'd0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 32'd0, 32'd0, 32'd0, 0);
    endtask

    task automatic read_cnt(input int s, output logic [CNT_W-1:0] v);
        cnt_sel = 4'(s);
        #1;
        v = cnt_data;
    endtask

    task automatic check_all(input string tag);
        logic [CNT_W-1:0] v;
        rec_t h;
        h.pc = '0; h.instr = '0; h.wd = '0;
        if (mq.size() > 0) h = mq[0];
        chk({tag, ".valid"}, 64'(trace_valid), 64'(mq.size() > 0));
        chk({tag, ".pc"},    64'(trace_pc),    64'(h.pc));
        chk({tag, ".instr"}, 64'(trace_instr), 64'(h.instr));
        chk({tag, ".wd"},    64'(trace_wd),    64'(h.wd));
        chk({tag, ".ovf"},   64'(trace_ovf),   64'(movf));
        chk({tag, ".done"},  64'(done),        64'(mdone));
        chk({tag, ".cause"}, 64'(done_cause),  64'(mcause));
        for (int s = 0; s < 16; s++) begin
            read_cnt(s, v);
            chk($sformatf("%s.cnt%0d", tag, s), 64'(v), (s <= 10) ? mcnt[s] : 64'd0);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [10];
        logic [5:0]  fns [8];
        logic [31:0] r;
        logic [5:0]  op;
        ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h09, 6'h0D};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h19, 6'h12};
        if ($urandom_range(0, 9) == 0) return 32'd0;
        r  = $urandom;
        op = ops[$urandom_range(0, 9)];
        if (op == 6'h00 && $urandom_range(0, 3) != 0) r[5:0] = fns[$urandom_range(0, 7)];
        return {op, r[25:0]};
    endfunction

    typedef struct {
        logic [31:0] instr;
        int          cls;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [CNT_W-1:0] v;
        logic [31:0]      pc;
        logic [31:0]      ins;
        int               npop;

        tbl = '{
            '{32'h00853020, 2}, '{32'h00853022, 2}, '{32'h00021080, 2},
            '{32'h00850019, 3}, '{32'h00003010, 3}, '{32'h03E00008, 9},
            '{32'h8C020004, 4}, '{32'hAC020004, 5}, '{32'h10430002, 6},
            '{32'h08000100, 7}, '{32'h0C000100, 7}, '{32'h24420001, 8},
            '{32'h34420001, 9}, '{32'h00000000, 1}
        };

        // Reset, then idle: first cycle after reset is IDLE.
        do_reset();
        check_all("rst");
        idle(5);
        read_cnt(0, v);
        chk("idle.cycles", 64'(v), 64'd4);
        chk("idle.valid", 64'(trace_valid), 64'd0);
        chk("idle.done", 64'(done), 64'd0);

        // Classification table: one retirement per vector after a fresh reset.
        foreach (tbl[k]) begin
            do_reset();
            idle(1);
            cycle(0, 1, 32'h100, tbl[k].instr, 32'h5A, 0);
            for (int s = 1; s <= 9; s++) begin
                read_cnt(s, v);
                chk($sformatf("tbl%0d.cls%0d", k, s), 64'(v), 64'(s == tbl[k].cls));
            end
            read_cnt(10, v);
            chk($sformatf("tbl%0d.total", k), 64'(v), 64'd1);
            chk($sformatf("tbl%0d.instr", k), 64'(trace_instr), 64'(tbl[k].instr));
        end

        // Class counting on consecutive cycles, then in-order drain.
        do_reset();
        idle(1);
        cycle(0, 1, 32'h00, 32'h00853020, 32'h11, 0);
        cycle(0, 1, 32'h04, 32'h8C020004, 32'h22, 0);
        cycle(0, 1, 32'h08, 32'h00000000, 32'h33, 0);
        cycle(0, 1, 32'h0C, 32'h24420001, 32'h44, 0);
        read_cnt(2, v);  chk("seq.add", 64'(v), 64'd1);
        read_cnt(4, v);  chk("seq.lw", 64'(v), 64'd1);
        read_cnt(1, v);  chk("seq.nop", 64'(v), 64'd1);
        read_cnt(8, v);  chk("seq.addiu", 64'(v), 64'd1);
        read_cnt(10, v); chk("seq.total", 64'(v), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("seq.pop%0d.pc", k), 64'(trace_pc), 64'(k * 4));
            chk($sformatf("seq.pop%0d.wd", k), 64'(trace_wd), 64'((k + 1) * 32'h11));
            cycle(0, 0, 32'd0, 32'd0, 32'd0, 1);
        end
        chk("seq.empty", 64'(trace_valid), 64'd0);
        check_all("seq");

        // Halt: self-loop J at 0x40.
        do_reset();
        idle(1);
        cycle(0, 1, 32'h40, 32'h08000010, 32'h0, 0);
        chk("halt.done", 64'(done), 64'd1);
        chk("halt.cause", 64'(done_cause), 64'd1);
        cycle(0, 1, 32'h44, 32'h00853020, 32'h1, 0);
        read_cnt(10, v); chk("halt.total", 64'(v), 64'd1);
        read_cnt(7, v);  chk("halt.j", 64'(v), 64'd1);
        read_cnt(2, v);  chk("halt.add", 64'(v), 64'd0);
        chk("halt.head", 64'(trace_pc), 64'h40);
        check_all("halt");

        // Watchdog alone.
        do_reset();
        idle(60);
        chk("wd.pre", 64'(done), 64'd0);
        read_cnt(0, v); chk("wd.pre_cycles", 64'(v), 64'd59);
        idle(1);
        chk("wd.done", 64'(done), 64'd1);
        chk("wd.cause", 64'(done_cause), 64'd2);
        idle(3);
        read_cnt(0, v); chk("wd.frozen", 64'(v), 64'd60);
        check_all("wd");

        // Watchdog and halt on the same edge.
        do_reset();
        idle(60);
        cycle(0, 1, 32'h40, 32'h08000010, 32'h0, 0);
        chk("both.cause", 64'(done_cause), 64'd3);
        check_all("both");

        // FIFO full and overflow.
        do_reset();
        idle(1);
        for (int k = 0; k < 16; k++) cycle(0, 1, 32'(k * 4), 32'h00853020, 32'(k), 0);
        chk("ovf.at16", 64'(trace_ovf), 64'd0);
        cycle(0, 1, 32'h40, 32'h00853020, 32'h99, 0);
        chk("ovf.at17", 64'(trace_ovf), 64'd1);
        cycle(0, 1, 32'h1000, 32'h00853020, 32'h77, 1);
        check_all("ovf");
        npop = 0;
        for (int c = 0; c < 40 && trace_valid; c++) begin
            chk($sformatf("ovf.pop%0d", npop), 64'(trace_pc),
                (npop < 15) ? 64'((npop + 1) * 4) : 64'h1000);
            npop++;
            cycle(0, 0, 32'd0, 32'd0, 32'd0, 1);
        end
        chk("ovf.retained", 64'(npop), 64'd16);

        // Reset mid-run with entries queued.
        do_reset();
        idle(1);
        for (int k = 0; k < 3; k++) cycle(0, 1, 32'(k * 4), 32'h8C020004, 32'(k), 0);
        do_reset();
        chk("mid.valid", 64'(trace_valid), 64'd0);
        chk("mid.pc", 64'(trace_pc), 64'd0);
        chk("mid.done", 64'(done), 64'd0);
        for (int s = 0; s < 11; s++) begin
            read_cnt(s, v);
            chk($sformatf("mid.cnt%0d", s), 64'(v), 64'd0);
        end

        // Random traffic against the model.
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int c = 0; c < 70; c++) begin
                pc  = {4'h0, 26'($urandom), 2'b00};
                ins = rand_instr();
                if ($urandom_range(0, 39) == 0) ins = {6'h02, pc[27:2]};
                cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, pc, ins,
                      $urandom, $urandom_range(0, 2) == 0);
                check_all($sformatf("rnd%0d.%0d", run, c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/pipe_trace_monitor.md
# pipe_trace_monitor

Synthesizable retirement monitor for the 5-stage MIPS pipeline. It taps the writeback stage and classifies every retired instruction into per-class counters, and it buffers `{pc, instr, wd}` records in a parametrised trace FIFO. It also ends a run on a self-loop halt or a cycle-limit watchdog. It replaces fixed-length, display-only simulation tracing with a parametrised, hardware-readable trace and a halt detector.

## Interface
- `DEPTH`, 16: trace FIFO entries; power of two, ≥2.
- `CNT_W`, 32: width of cycle and class counters.
- `MAX_CYCLES`, 60: watchdog limit in RUN cycles; ≥1, fits in CNT_W.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  an instruction retires this cycle.
- `wb_pc`  in  32  PC of the retiring instruction.
- `wb_instr`  in  32  instruction word of the retiring instruction.
- `wb_wd`  in  32  register-file write data of the retiring instruction.
- `trace_ready`  in  1  consumer pops the FIFO head.
- `trace_valid`  out  1  FIFO non-empty.
- `trace_pc`, `trace_instr`, `trace_wd`  out  32 each  FIFO head record.
- `trace_ovf`  out  1  sticky: a push was dropped because the FIFO was full.
- `cnt_sel`  in  4  counter select.
- `cnt_data`  out  CNT_W  selected counter value (combinational read).
- `done`  out  1  run ended.
- `done_cause`  out  2  01 = halt, 10 = timeout, 11 = both in the same cycle, 00 = not done.

## Operation
- **FSM states:** IDLE → RUN → DONE.
  - `rst` forces IDLE.
  - IDLE → RUN on the first cycle with `rst` low.
  - RUN → DONE on halt or timeout.
  - DONE holds until `rst`.
- **Retirement acceptance:** a retirement is accepted only when `wb_valid` is high and state is RUN. Retirements in IDLE or DONE are ignored entirely.
- **Classification** (`opcode = instr[31:26]`, `funct = instr[5:0]`). The class selects the `cnt_sel` index:
  - 0: cycles
  - 1: NOP (`instr == 0`, checked first)
  - 2: R-ALU (opcode 0, funct ∈ {0x20, 0x22, 0x24, 0x25, 0x2A, 0x00})
  - 3: MUL (opcode 0, funct ∈ {0x19, 0x10, 0x12})
  - 4: LW (0x23)
  - 5: SW (0x2B)
  - 6: BEQ (0x04)
  - 7: J/JAL (0x02, 0x03)
  - 8: ADDIU (0x09)
  - 9: OTHER
  - 10: total retired
  - 11–15: read as 0
- **Counters:** each accepted retirement increments exactly one class counter plus the total counter. The cycle counter increments every RUN cycle. All counters saturate at 2^CNT_W−1.
- **Halt detection:** triggered by an accepted J (opcode 0x02) whose target `{wb_pc+4[31:28], instr[25:0], 2'b00}` equals `wb_pc`. The halting J is itself counted and pushed.
- **Timeout:** fires in the RUN cycle where the cycle counter goes from MAX_CYCLES−1 to MAX_CYCLES.
- **Trace FIFO:**
  - Push on accepted retirement.
  - Pop when `trace_ready && trace_valid`; the FIFO keeps draining in every state except reset.
  - Push when full:
    - If a pop occurs in the same cycle, the push is accepted; no drop.
    - Otherwise the record is dropped and `trace_ovf` is set.
  - Pop with no data is ignored. If a push occurs in the same cycle, the record is stored.
  - Read and write pointers wrap modulo DEPTH; an occupancy count distinguishes full from empty.

## Timing
- **Reset values:** all counters 0, FIFO empty, `trace_valid` 0, `trace_pc`/`trace_instr`/`trace_wd` 0 while empty, `trace_ovf` 0, `done` 0, `done_cause` 00, state IDLE.
- **Push latency:** a record pushed at edge N is visible on `trace_*` after edge N when the FIFO was empty (1-cycle latency).
- **Counter latency:** a counter updated at edge N is visible on `cnt_data` after edge N.
- **Done latency:** `done` and `done_cause` are registered. They rise after the edge that accepts the halting J or reaches the timeout. The halting retirement is recorded on that same edge.
- **Done stability:** in DONE, counters freeze and `done_cause` is stable.
- **Reset mid-run:** `rst` during RUN or DONE clears everything on that edge. FIFO contents are discarded.

## Test plan
- **Reset, then idle:** reset, then 5 idle cycles with `wb_valid` = 0 → `cnt_sel` = 0 reads 4 (first cycle after reset is IDLE), `trace_valid` = 0, `done` = 0.
- **Class counting:** retire ADD (0x00853020), LW (0x8C020004), NOP (0), ADDIU (0x24420001) on consecutive cycles → counters 2, 4, 1, 8 each read 1, counter 10 reads 4. FIFO pops in order with matching `pc`/`wd`.
- **Halt detection:** retire J at pc 0x40 with instr 0x08000010 → `done` = 1, `done_cause` = 01 the next cycle. Further retirements are not counted.
- **Watchdog:** MAX_CYCLES = 60, no halt → `done_cause` = 10 after RUN cycle 60, cycle counter frozen at 60. Halt on that same cycle → 11.
- **FIFO full and overflow:** DEPTH = 16, `trace_ready` = 0, 17 retirements → `trace_ovf` = 1 and 16 entries retained. Then push+pop in the same cycle while full → no further drop, occupancy stays 16.
- **Reset mid-run:** assert `rst` with 3 entries queued and counters non-zero → next cycle everything reads 0 and `trace_valid` = 0.
